register_bank: RTL and testbench
================================

# register_bank

- Write-side counterpart of the writeback stage: a 32 x 32-bit MIPS general-purpose register file that accepts the writeback data/address pair.
- Provides two combinational read ports to the ID stage, with write-through bypass.
- Also provides a handshaked dump sequencer that streams all 32 registers to the debug unit.
- Sits between WB (write side), ID (read side) and the debug/UART unit (dump side).

## Interface

Parameters:
- BITS_SIZE, 32, data word width
- BITS_REGS, 5, register address width
- REG_COUNT, 32, number of registers (2^BITS_REGS)

Ports:
- Clock and reset (already decided): one clock, i_clk; reset i_reset is synchronous and active-high.
- i_clk  input  1  single clock; all state updates on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_wb_reg_write  input  1  write enable from WB control
- i_wb_register_adrr_result  input  BITS_REGS  write address (WB o_wb_register_adrr_result)
- i_wb_data_write  input  BITS_SIZE  write data (WB o_wb_data_write)
- i_id_rs  input  BITS_REGS  read address A
- i_id_rt  input  BITS_REGS  read address B
- o_id_data_rs  output  BITS_SIZE  read data A
- o_id_data_rt  output  BITS_SIZE  read data B
- i_dbg_dump  input  1  one-cycle pulse; starts a full register dump
- i_dbg_ready  input  1  debug unit accepts current dump word
- o_dbg_valid  output  1  dump word valid
- o_dbg_addr  output  BITS_REGS  index of the dump word
- o_dbg_data  output  BITS_SIZE  dump word
- o_dbg_busy  output  1  dump in progress (state != IDLE)

## Operation

- **Write:**
  - At the rising edge, if i_wb_reg_write=1 and the address is not 0, the register at that address is loaded with i_wb_data_write.
  - Writes to register 0 are discarded; register 0 always reads 0.
- **Read:**
  - Reads are combinational.
  - o_id_data_rs = 0 if i_id_rs==0.
  - Otherwise o_id_data_rs = i_wb_data_write if i_wb_reg_write and the write address equals i_id_rs (same-cycle bypass).
  - Otherwise o_id_data_rs = the stored register.
  - o_id_data_rt follows the same rule using i_id_rt.
- **Dump FSM**, states IDLE, SEND, DONE:
  - IDLE: o_dbg_valid=0. On i_dbg_dump=1: index cleared to 0, go to SEND.
  - SEND: o_dbg_valid=1, o_dbg_addr=index, o_dbg_data=register[index] with the same bypass rule as the read ports.
  - SEND with i_dbg_ready=1: handshake completes. If index==REG_COUNT-1 go to DONE, else index+1.
  - SEND with i_dbg_ready=0: hold addr/data stable. Data may change only if a WB write hits the same index; the bypass value is shown.
  - DONE: o_dbg_valid=0 for one cycle, then IDLE.
  - i_dbg_dump in SEND or DONE is ignored.
- Writes from WB continue normally during a dump; the dump is not a pipeline stall source.
- Index counter is BITS_REGS wide. The DONE check occurs before the increment, so there is no wrap.

## Timing

- Reset, applied at a rising edge with i_reset=1:
  - all 32 registers = 0;
  - FSM = IDLE, index = 0;
  - o_dbg_valid=0, o_dbg_busy=0, o_dbg_addr=0, o_dbg_data=0;
  - o_id_data_rs/rt = 0 (bypass still applies combinationally if a write is presented).
- Reset mid-dump aborts the dump; the next cycle is IDLE with valid=0.
- A write during the reset cycle is discarded.
- Write latency: data presented at edge N is stored at N. It is visible combinationally in the same cycle via bypass, and from storage from cycle N+1.
- Read latency: 0 cycles (combinational).
- Dump:
  - i_dbg_dump high at edge N → o_dbg_valid=1 from cycle N+1.
  - With i_dbg_ready held at 1 the full dump takes 32 cycles of valid, then 1 cycle in DONE, then IDLE.
  - o_dbg_busy is high for 33 cycles.
- Simultaneous i_dbg_dump and i_reset: reset wins.

## Test plan

1. **Reset:** after reset, read r0..r31 on rs/rt → all 0x00000000; o_dbg_valid=0, o_dbg_busy=0.
2. **Write/read:**
   - Write r5=0xDEADBEEF, then read rs=5 next cycle → 0xDEADBEEF.
   - Write r0=0x12345678 → rs=0 reads 0.
3. **Bypass:** same cycle as a write of r9=0x0000_00A5, set rs=9, rt=9 → both outputs 0x000000A5 before the edge. Set rt=10 → old r10 value.
4. **Full dump, ready=1:**
   - Preload rN=N*0x10, pulse i_dbg_dump.
   - Required: 32 consecutive valid beats with addr 0..31 and data 0,0x10,…,0x1F0.
   - Then busy drops after the DONE cycle.
5. **Backpressure plus concurrent write:**
   - During a dump, hold ready=0 at index 7 for 4 cycles → addr/data stable.
   - Write r7=0xCAFEF00D in the 3rd stall cycle → o_dbg_data becomes 0xCAFEF00D.
   - Release ready → next beat addr=8.
6. **Reset mid-dump:** assert i_reset at index 12 → next cycle valid=0, busy=0, all registers 0. A new i_dbg_dump restarts at addr 0.

Source files
------------

// File: rtl/register_bank_if.sv
// -----------------------------------------------------------------------------
// register_bank_if
//
// Purpose: bundles the three traffic groups that meet at the register bank:
//          the writeback write pair, the ID-stage read ports and the debug
//          dump stream. Member names are written from the register bank's
//          point of view (i_ = into the bank, o_ = out of the bank).
//
// Modports:
//   slave  - the register bank itself (consumes i_*, drives o_*)
//   master - the surrounding pipeline / debug unit (drives i_*, consumes o_*)
//
// Members:
//   i_wb_reg_write             write enable from WB
//   i_wb_register_adrr_result  write address
//   i_wb_data_write            write data
//   i_id_rs / i_id_rt          read addresses A / B
//   o_id_data_rs / o_id_data_rt read data A / B (combinational, bypassed)
//   i_dbg_dump                 one-cycle pulse starting a full dump
//   i_dbg_ready                debug unit accepts the current dump word
//   o_dbg_valid                dump word valid
//   o_dbg_addr / o_dbg_data    index and value of the dump word
//   o_dbg_busy                 dump sequencer not idle
// -----------------------------------------------------------------------------
interface register_bank_if #(
   parameter int BITS_SIZE = 32,
   parameter int BITS_REGS = 5
);
   // writeback side
   logic                 i_wb_reg_write;
   logic [BITS_REGS-1:0] i_wb_register_adrr_result;
   logic [BITS_SIZE-1:0] i_wb_data_write;

   // decode side
   logic [BITS_REGS-1:0] i_id_rs;
   logic [BITS_REGS-1:0] i_id_rt;
   logic [BITS_SIZE-1:0] o_id_data_rs;
   logic [BITS_SIZE-1:0] o_id_data_rt;

   // debug dump side
   logic                 i_dbg_dump;
   logic                 i_dbg_ready;
   logic                 o_dbg_valid;
   logic [BITS_REGS-1:0] o_dbg_addr;
   logic [BITS_SIZE-1:0] o_dbg_data;
   logic                 o_dbg_busy;

   modport slave (
      input  i_wb_reg_write,
      input  i_wb_register_adrr_result,
      input  i_wb_data_write,
      input  i_id_rs,
      input  i_id_rt,
      output o_id_data_rs,
      output o_id_data_rt,
      input  i_dbg_dump,
      input  i_dbg_ready,
      output o_dbg_valid,
      output o_dbg_addr,
      output o_dbg_data,
      output o_dbg_busy
   );

   modport master (
      output i_wb_reg_write,
      output i_wb_register_adrr_result,
      output i_wb_data_write,
      output i_id_rs,
      output i_id_rt,
      input  o_id_data_rs,
      input  o_id_data_rt,
      output i_dbg_dump,
      output i_dbg_ready,
      input  o_dbg_valid,
      input  o_dbg_addr,
      input  o_dbg_data,
      input  o_dbg_busy
   );
endinterface

// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
//
// Purpose: 32 x 32-bit MIPS general-purpose register file. Accepts the
//          writeback address/data pair, serves two combinational read ports to
//          the ID stage with same-cycle write-through bypass, and contains a
//          valid/ready dump sequencer that streams every register to the debug
//          unit without stalling the pipeline.
//
// Ports:
//   i_clk    single clock, all state updates on the rising edge
//   i_reset  synchronous, active-high reset (clears every register and
//            aborts any dump in progress)
//   bus      register_bank_if.slave - WB write, ID read and debug dump groups
// -----------------------------------------------------------------------------
module register_bank #(
   parameter int BITS_SIZE = 32,
   parameter int BITS_REGS = 5,
   parameter int REG_COUNT = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   register_bank_if.slave  bus
);

   // read port numbering: two decode ports plus the dump sequencer's own port
   localparam int PORT_RS   = 0;
   localparam int PORT_RT   = 1;
   localparam int PORT_DBG  = 2;
   localparam int NUM_PORTS = 3;

   localparam logic [BITS_REGS-1:0] LAST_INDEX = BITS_REGS'(REG_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   logic [BITS_SIZE-1:0] w_regs    [REG_COUNT];
   logic [BITS_REGS-1:0] w_rd_addr [NUM_PORTS];
   logic [BITS_SIZE-1:0] w_rd_data [NUM_PORTS];

   state_t               r_state;
   state_t               w_state_next;
   logic [BITS_REGS-1:0] r_index;
   logic [BITS_REGS-1:0] w_index_next;
   logic                 w_dbg_valid;
   logic                 w_dbg_busy;

   // ------------------------------------------------------------------------
   // Register storage
   // Register 0 has no storage at all: it is tied to zero, so a write to it
   // simply has nowhere to land. Every other register is a plain flop word
   // with its own address decode; reset must clear all of them in one cycle,
   // which rules out a RAM macro.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign w_regs[gi] = '0;
         end else begin : g_store
            logic                 w_wr_sel;
            logic [BITS_SIZE-1:0] r_value;

            assign w_wr_sel = bus.i_wb_reg_write &&
                              (bus.i_wb_register_adrr_result == BITS_REGS'(gi));

            always_ff @(posedge i_clk) begin
               if (i_reset) begin
                  r_value <= '0;
               end else if (w_wr_sel) begin
                  r_value <= bus.i_wb_data_write;
               end
            end

            assign w_regs[gi] = r_value;
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Read ports
   // All three ports share one rule: address 0 reads zero, a write presented
   // this cycle to the same address is forwarded, otherwise the stored word.
   // The dump port uses the same rule so a stalled beat picks up a concurrent
   // WB write to the word being shown.
   // ------------------------------------------------------------------------
   assign w_rd_addr[PORT_RS]  = bus.i_id_rs;
   assign w_rd_addr[PORT_RT]  = bus.i_id_rt;
   assign w_rd_addr[PORT_DBG] = r_index;

   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rd
         logic [BITS_SIZE-1:0] w_data;

         always_comb begin
            w_data = '0;
            if (w_rd_addr[gi] != '0) begin
               if (bus.i_wb_reg_write &&
                   (bus.i_wb_register_adrr_result == w_rd_addr[gi])) begin
                  w_data = bus.i_wb_data_write;
               end else begin
                  w_data = w_regs[w_rd_addr[gi]];
               end
            end
         end

         assign w_rd_data[gi] = w_data;
      end
   endgenerate

   assign bus.o_id_data_rs = w_rd_data[PORT_RS];
   assign bus.o_id_data_rt = w_rd_data[PORT_RT];

   // ------------------------------------------------------------------------
   // Dump sequencer: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_index <= '0;
      end else begin
         r_state <= w_state_next;
         r_index <= w_index_next;
      end
   end

   // ------------------------------------------------------------------------
   // Dump sequencer: next state and outputs
   // The last-index test happens before the increment, so the index never
   // wraps back to 0 after the final beat.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_index_next = r_index;
      w_dbg_valid  = 1'b0;
      w_dbg_busy   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.i_dbg_dump) begin
               w_state_next = ST_SEND;
               w_index_next = '0;
            end
         end

         ST_SEND: begin
            w_dbg_valid = 1'b1;
            w_dbg_busy  = 1'b1;
            if (bus.i_dbg_ready) begin
               if (r_index == LAST_INDEX) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_index_next = r_index + 1'b1;
               end
            end
         end

         ST_DONE: begin
            w_dbg_busy   = 1'b1;
            w_state_next = ST_IDLE;
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Address and data are forced to zero outside SEND so the debug side sees
   // a clean bus while idle (the index keeps its last value in IDLE/DONE).
   assign bus.o_dbg_valid = w_dbg_valid;
   assign bus.o_dbg_busy  = w_dbg_busy;
   assign bus.o_dbg_addr  = w_dbg_valid ? r_index : '0;
   assign bus.o_dbg_data  = w_dbg_valid ? w_rd_data[PORT_DBG] : '0;

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

   localparam int BS = 32;
   localparam int BR = 5;
   localparam int RC = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   register_bank_if #(.BITS_SIZE(BS), .BITS_REGS(BR)) bus ();

   register_bank #(.BITS_SIZE(BS), .BITS_REGS(BR), .REG_COUNT(RC)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // ---------------- reference model ----------------
   logic [31:0] mdl [32];
   bit          d_act;    // dump streaming
   bit          d_done;   // one cycle after last beat
   int          d_idx;

   int vectors     = 0;
   int miscompares = 0;

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (bus.i_wb_reg_write && bus.i_wb_register_adrr_result == a)
         return bus.i_wb_data_write;
      return mdl[a];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("rs",    bus.o_id_data_rs, exp_read(bus.i_id_rs));
      chk("rt",    bus.o_id_data_rt, exp_read(bus.i_id_rt));
      chk("valid", 32'(bus.o_dbg_valid), 32'(d_act));
      chk("busy",  32'(bus.o_dbg_busy),  32'(d_act || d_done));
      chk("addr",  32'(bus.o_dbg_addr),  d_act ? d_idx : 0);
      chk("data",  bus.o_dbg_data,       d_act ? exp_read(5'(d_idx)) : 32'h0);
   endtask

   // compare at the falling edge, away from the active edge
   task automatic sample();
      @(negedge clk);
      check_all();
   endtask

   // advance one rising edge and update the model from the inputs seen there
   task automatic commit();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
         d_act = 1'b0; d_done = 1'b0; d_idx = 0;
      end else begin
         if (bus.i_wb_reg_write && bus.i_wb_register_adrr_result != 5'd0)
            mdl[bus.i_wb_register_adrr_result] = bus.i_wb_data_write;
         if (d_done) begin
            d_done = 1'b0;
         end else if (d_act) begin
            if (bus.i_dbg_ready) begin
               if (d_idx == 31) begin d_act = 1'b0; d_done = 1'b1; end
               else d_idx++;
            end
         end else if (bus.i_dbg_dump) begin
            d_act = 1'b1; d_idx = 0;
         end
      end
      #1;
   endtask

   task automatic set_write(input logic we, input logic [4:0] a, input logic [31:0] d);
      bus.i_wb_reg_write = we;
      bus.i_wb_register_adrr_result = a;
      bus.i_wb_data_write = d;
   endtask

   task automatic drain();
      bus.i_dbg_dump  = 1'b0;
      bus.i_dbg_ready = 1'b1;
      for (int k = 0; k < 100 && (d_act || d_done); k++) begin
         sample(); commit();
      end
      sample();
      chk("drain_idle", 32'(bus.o_dbg_busy), 32'h0);
      commit();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      set_write(1'b0, 5'd0, 32'h0);
      bus.i_id_rs = 5'd0; bus.i_id_rt = 5'd0;
      bus.i_dbg_dump = 1'b0; bus.i_dbg_ready = 1'b1;
      commit(); commit();
      rst = 1'b0;

      // 1. reset state
      for (int i = 0; i < 32; i++) begin
         bus.i_id_rs = 5'(i); bus.i_id_rt = 5'(31 - i);
         sample();
         chk("reset_rs", bus.o_id_data_rs, 32'h0);
         chk("reset_rt", bus.o_id_data_rt, 32'h0);
         commit();
      end
      $display("reset check: r0..r31 read back");

      // 2. write / read, write to r0 discarded
      set_write(1'b1, 5'd5, 32'hDEADBEEF);
      sample(); commit();
      set_write(1'b0, 5'd0, 32'h0);
      bus.i_id_rs = 5'd5;
      sample(); chk("r5_read", bus.o_id_data_rs, 32'hDEADBEEF); commit();
      $display("write r5=deadbeef read=%08h", bus.o_id_data_rs);
      set_write(1'b1, 5'd0, 32'h12345678);
      bus.i_id_rs = 5'd0;
      sample(); chk("r0_bypass", bus.o_id_data_rs, 32'h0); commit();
      set_write(1'b0, 5'd0, 32'h0);
      sample(); chk("r0_read", bus.o_id_data_rs, 32'h0); commit();
      $display("write r0=12345678 read=%08h", bus.o_id_data_rs);

      // 3. bypass
      set_write(1'b1, 5'd10, 32'h00001111);
      sample(); commit();
      set_write(1'b1, 5'd9, 32'h000000A5);
      bus.i_id_rs = 5'd9; bus.i_id_rt = 5'd9;
      sample();
      chk("byp_rs", bus.o_id_data_rs, 32'h000000A5);
      chk("byp_rt", bus.o_id_data_rt, 32'h000000A5);
      bus.i_id_rt = 5'd10;
      #1;
      check_all();
      chk("byp_rt_old", bus.o_id_data_rt, 32'h00001111);
      commit();
      set_write(1'b0, 5'd0, 32'h0);
      $display("bypass r9=000000a5 rt(r10)=%08h", bus.o_id_data_rt);

      // 4. full dump with ready held high
      for (int i = 0; i < 32; i++) begin
         set_write(1'b1, 5'(i), 32'(i * 16));
         sample(); commit();
      end
      set_write(1'b0, 5'd0, 32'h0);
      bus.i_dbg_dump = 1'b1; bus.i_dbg_ready = 1'b1;
      sample(); chk("dump_start_valid", 32'(bus.o_dbg_valid), 32'h0); commit();
      bus.i_dbg_dump = 1'b0;
      for (int i = 0; i < 32; i++) begin
         sample();
         chk("beat_valid", 32'(bus.o_dbg_valid), 32'h1);
         chk("beat_addr",  32'(bus.o_dbg_addr), 32'(i));
         chk("beat_data",  bus.o_dbg_data, 32'(i * 16));
         $display("beat addr=%0d data=%08h", bus.o_dbg_addr, bus.o_dbg_data);
         commit();
      end
      sample();
      chk("done_valid", 32'(bus.o_dbg_valid), 32'h0);
      chk("done_busy",  32'(bus.o_dbg_busy),  32'h1);
      commit();
      sample(); chk("idle_busy", 32'(bus.o_dbg_busy), 32'h0); commit();

      // 5. backpressure at index 7 with a concurrent write to r7
      bus.i_dbg_dump = 1'b1;
      sample(); commit();
      bus.i_dbg_dump = 1'b0;
      for (int i = 0; i < 7; i++) begin sample(); commit(); end
      bus.i_dbg_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         if (s == 2) set_write(1'b1, 5'd7, 32'hCAFEF00D);
         else        set_write(1'b0, 5'd0, 32'h0);
         sample();
         chk("stall_addr", 32'(bus.o_dbg_addr), 32'd7);
         chk("stall_data", bus.o_dbg_data, (s < 2) ? 32'h70 : 32'hCAFEF00D);
         $display("stall %0d addr=%0d data=%08h", s, bus.o_dbg_addr, bus.o_dbg_data);
         commit();
      end
      set_write(1'b0, 5'd0, 32'h0);
      bus.i_dbg_ready = 1'b1;
      sample(); chk("release_data", bus.o_dbg_data, 32'hCAFEF00D); commit();
      sample(); chk("next_addr", 32'(bus.o_dbg_addr), 32'd8); commit();
      drain();

      // 6. reset mid-dump
      bus.i_dbg_dump = 1'b1;
      sample(); commit();
      bus.i_dbg_dump = 1'b0;
      for (int i = 0; i < 12; i++) begin sample(); commit(); end
      rst = 1'b1;
      sample(); chk("pre_rst_addr", 32'(bus.o_dbg_addr), 32'd12); commit();
      rst = 1'b0;
      sample();
      chk("post_rst_valid", 32'(bus.o_dbg_valid), 32'h0);
      chk("post_rst_busy",  32'(bus.o_dbg_busy),  32'h0);
      commit();
      for (int i = 0; i < 32; i++) begin
         bus.i_id_rs = 5'(i); bus.i_id_rt = 5'(31 - i);
         sample();
         chk("post_rst_rs", bus.o_id_data_rs, 32'h0);
         chk("post_rst_rt", bus.o_id_data_rt, 32'h0);
         commit();
      end
      bus.i_dbg_dump = 1'b1;
      sample(); commit();
      bus.i_dbg_dump = 1'b0;
      sample();
      chk("restart_valid", 32'(bus.o_dbg_valid), 32'h1);
      chk("restart_addr",  32'(bus.o_dbg_addr),  32'h0);
      commit();
      $display("reset mid-dump: restart addr=%0d", bus.o_dbg_addr);
      drain();

      // 7. randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         set_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         bus.i_id_rs = ($urandom_range(0, 3) == 0) ? bus.i_wb_register_adrr_result
                                                   : 5'($urandom_range(0, 31));
         bus.i_id_rt = ($urandom_range(0, 3) == 0) ? bus.i_wb_register_adrr_result
                                                   : 5'($urandom_range(0, 31));
         bus.i_dbg_dump  = ($urandom_range(0, 19) == 0);
         bus.i_dbg_ready = ($urandom_range(0, 3) != 0);
         rst             = ($urandom_range(0, 149) == 0);
         sample();
         if (bus.o_dbg_valid && bus.i_dbg_ready)
            $display("rnd beat addr=%0d data=%08h", bus.o_dbg_addr, bus.o_dbg_data);
         commit();
      end
      rst = 1'b0;
      set_write(1'b0, 5'd0, 32'h0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
